rvvi_host_cmd_rx: RTL
=====================

RVVI_HOST_CMD_RX -- requirements
Module: rvvi_host_cmd_rx

Interface
REQ-001 The block SHALL have parameter DEV_MAC, default 48'h5402_1111_6843, meaning the expected destination MAC.
REQ-002 The block SHALL have parameter HOST_MAC, default 48'h8f54_0000_1654, meaning the expected source MAC.
REQ-003 The block SHALL have parameter ETHER_TYPE, default 16'h005c, meaning the expected EtherType field.
REQ-004 Port clk: input, 1 bit, the single clock.
REQ-005 Port reset: input, 1 bit, asynchronous, active-high.
REQ-006 Ports RvviAxiRdata, RvviAxiRstrb, RvviAxiRvalid, RvviAxiRlast, RvviAxiRuser: inputs, 32/4/1/1/1 bits, the MAC receive AXI-stream; Ruser=1 on the last beat marks a bad frame.
REQ-007 Port RvviAxiRready: output, 1 bit, stream ready.
REQ-008 Port TriggerPulse: output, 1 bit, one-cycle pulse on an accepted trigger command.
REQ-009 Port SlowPulse: output, 1 bit, one-cycle pulse on an accepted slow-down command.
REQ-010 Port HostFillAmt: output, 32 bits, argument of the last accepted slow-down command.
REQ-011 Ports FrameCount and DropCount: outputs, 16 bits each, counts of accepted and dropped frames.

Function
REQ-012 RvviAxiRready SHALL be 1 in every cycle when reset is low; the block never back-pressures.
REQ-013 A beat SHALL transfer when RvviAxiRvalid=1 and RvviAxiRready=1; the word index counts beats 0..5 and saturates at 6.
REQ-014 Expected layout: w0=DEV_MAC[31:0]; w1={HOST_MAC[15:0],DEV_MAC[47:32]}; w2=HOST_MAC[47:16]; w3[15:0]=ETHER_TYPE; Cmd={w4,w3[31:16]}; w5=argument; words after w5 are ignored.
REQ-015 Cmd=48'h6e69_6769_7274 SHALL decode as TRIGGER, Cmd=48'h656d_776f_6c73 SHALL decode as SLOW, and any other value as UNKNOWN.
REQ-016 FSM states: IDLE, HDR (w0-w3), CMD (w4-w5), DRAIN; IDLE->HDR on the first beat; HDR->CMD after w3 matches; CMD->DRAIN after w5; any header mismatch or non-final beat with Rstrb!=4'hF SHALL go to DRAIN with the drop flag set.
REQ-017 A beat with Rlast=1 from any state SHALL end the frame and return the FSM to IDLE, so that the next beat is w0 of the next frame.
REQ-018 The frame SHALL be accepted only if the header matches, at least 6 full beats were received, Ruser=0 on the last beat, and the command is TRIGGER or SLOW; otherwise it SHALL be dropped.
REQ-019 TriggerPulse or SlowPulse SHALL assert for exactly one cycle, the cycle after the Rlast beat, and HostFillAmt SHALL update in the same cycle as SlowPulse.
REQ-020 A frame shorter than 6 beats, with Rlast before w5, SHALL be dropped with no pulse.
REQ-021 Back-to-back frames with no idle cycle SHALL each be evaluated independently; the pulse of frame N SHALL NOT be lost when frame N+1 starts.
REQ-022 FrameCount SHALL increment on each accepted frame, DropCount SHALL increment on each dropped frame, and both SHALL saturate at 16'hFFFF.

Reset
REQ-023 While reset is high, the block SHALL force FSM=IDLE, word index=0, drop flag=0, TriggerPulse=0, SlowPulse=0, HostFillAmt=0, FrameCount=0, DropCount=0, and RvviAxiRready=0.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame with no pulse and no count; the first beat after reset is w0.

Configuration
REQ-025 With macro RVVI_RX_STATS_EN defined, FrameCount and DropCount SHALL be implemented per REQ-022; without it, both SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-026 The shared package SHALL hold the command codes, the word-index constants, the FSM state enum, and the default MAC and EtherType values.
REQ-027 The block SHALL contain one sub-module, rvvi_sat_counter, a 16-bit saturating incrementer instantiated twice under RVVI_RX_STATS_EN.

Verification
REQ-028 A valid TRIGGER frame of 6 beats plus 9 pad beats SHALL produce a TriggerPulse one cycle after Rlast, with FrameCount=1.
REQ-029 A valid SLOW frame with w5=32'h0000_0200 SHALL produce a SlowPulse and HostFillAmt=32'h200, and TriggerPulse SHALL stay 0.
REQ-030 A frame with DEV_MAC byte 0 changed to 8'h44 SHALL produce no pulse and DropCount=1; a frame with a correct header but Ruser=1 SHALL likewise give no pulse and increment DropCount.
REQ-031 A 4-beat frame, with Rlast on w3, immediately followed by a valid TRIGGER frame SHALL give exactly one TriggerPulse, with DropCount=1 and FrameCount=1.
REQ-032 A reset asserted on w4 of a SLOW frame, then one valid SLOW frame, SHALL give exactly one SlowPulse and FrameCount=1; with RVVI_RX_STATS_EN undefined, both counters SHALL read 0 throughout.

Source files
------------

// File: rtl/rvvi_host_cmd_rx_pkg.sv
// Shared definitions for the RVVI host command receiver: default addressing,
// command codes, word-index constants, FSM state and command decode.
package rvvi_host_cmd_rx_pkg;

  localparam logic [47:0] DEF_DEV_MAC    = 48'h5402_1111_6843;
  localparam logic [47:0] DEF_HOST_MAC   = 48'h8f54_0000_1654;
  localparam logic [15:0] DEF_ETHER_TYPE = 16'h005c;

  // Command text, stored in the order the bytes arrive on the wire ("trigin", "slowme").
  localparam logic [47:0] CMD_TRIGGER_CODE = 48'h6e69_6769_7274;
  localparam logic [47:0] CMD_SLOW_CODE    = 48'h656d_776f_6c73;

  localparam logic [2:0] W_DST_LO = 3'd0;
  localparam logic [2:0] W_MIX    = 3'd1;
  localparam logic [2:0] W_SRC_HI = 3'd2;
  localparam logic [2:0] W_ETYPE  = 3'd3;
  localparam logic [2:0] W_CMD    = 3'd4;
  localparam logic [2:0] W_ARG    = 3'd5;
  localparam logic [2:0] W_SAT    = 3'd6;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_CMD,
    ST_DRAIN
  } rx_state_e;

  typedef enum logic [1:0] {
    CMD_UNKNOWN,
    CMD_TRIGGER,
    CMD_SLOW
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic [47:0] cmd);
    if (cmd == CMD_TRIGGER_CODE)   return CMD_TRIGGER;
    else if (cmd == CMD_SLOW_CODE) return CMD_SLOW;
    else                           return CMD_UNKNOWN;
  endfunction

endpackage

// File: rtl/rvvi_host_cmd_rx_sat_counter.sv
// 16-bit event counter that sticks at its maximum instead of wrapping.
module rvvi_sat_counter
  import rvvi_host_cmd_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rvvi_host_cmd_rx.sv
// Receives host command frames from the MAC AXI stream and emits trigger /
// slow-down pulses. Frame statistics are built only when RVVI_RX_STATS_EN is defined.
module rvvi_host_cmd_rx
  import rvvi_host_cmd_rx_pkg::*;
#(
  parameter logic [47:0] DEV_MAC    = DEF_DEV_MAC,
  parameter logic [47:0] HOST_MAC   = DEF_HOST_MAC,
  parameter logic [15:0] ETHER_TYPE = DEF_ETHER_TYPE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RvviAxiRdata,
  input  logic [3:0]  RvviAxiRstrb,
  input  logic        RvviAxiRvalid,
  input  logic        RvviAxiRlast,
  input  logic        RvviAxiRuser,
  output logic        RvviAxiRready,
  output logic        TriggerPulse,
  output logic        SlowPulse,
  output logic [31:0] HostFillAmt,
  output logic [15:0] FrameCount,
  output logic [15:0] DropCount
);

  rx_state_e   r_state;
  logic [2:0]  r_widx;
  logic        r_drop;
  logic [47:0] r_cmd;
  logic [31:0] r_arg;
  logic        r_trigger_pulse;
  logic        r_slow_pulse;
  logic [31:0] r_host_fill;

  logic        w_ready;
  logic        w_beat;
  logic        w_last;
  logic [31:0] w_exp_word;
  logic [31:0] w_exp_mask;
  logic        w_hdr_bad;
  logic        w_strb_bad;
  logic        w_drop_now;
  logic        w_hdr_passed;
  logic [31:0] w_arg;
  cmd_e        w_cmd_kind;
  logic        w_accept;

  // Ready is held low only by reset; the receiver never back-pressures.
  assign w_ready = ~reset;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    w_exp_word = '0;
    w_exp_mask = '0;
    case (r_widx)
      W_DST_LO: begin w_exp_word = DEV_MAC[31:0];                   w_exp_mask = 32'hFFFF_FFFF; end
      W_MIX:    begin w_exp_word = {HOST_MAC[15:0], DEV_MAC[47:32]}; w_exp_mask = 32'hFFFF_FFFF; end
      W_SRC_HI: begin w_exp_word = HOST_MAC[47:16];                  w_exp_mask = 32'hFFFF_FFFF; end
      W_ETYPE:  begin w_exp_word = {16'h0000, ETHER_TYPE};           w_exp_mask = 32'h0000_FFFF; end
      default:  begin w_exp_word = '0;                               w_exp_mask = '0;            end
    endcase
  end

  assign w_beat     = RvviAxiRvalid & w_ready;
  assign w_last     = w_beat & RvviAxiRlast;
  assign w_hdr_bad  = ((RvviAxiRdata ^ w_exp_word) & w_exp_mask) != 32'h0;
  // A short final beat is normal only in the padding after the argument word.
  assign w_strb_bad = (RvviAxiRstrb != 4'hF) && (!RvviAxiRlast || (r_widx <= W_ARG));
  assign w_drop_now = r_drop | w_hdr_bad | w_strb_bad;

  assign w_hdr_passed = (r_state == ST_CMD) || (r_state == ST_DRAIN);
  assign w_arg        = (r_widx == W_ARG) ? RvviAxiRdata : r_arg;
  assign w_cmd_kind   = decode_cmd(r_cmd);
  assign w_accept     = w_last && !w_drop_now && w_hdr_passed && (r_widx >= W_ARG) &&
                        !RvviAxiRuser && (w_cmd_kind != CMD_UNKNOWN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_widx  <= '0;
      r_drop  <= 1'b0;
      r_cmd   <= '0;
      r_arg   <= '0;
    end else if (w_beat) begin
      case (r_widx)
        W_ETYPE: r_cmd[15:0]  <= RvviAxiRdata[31:16];
        W_CMD:   r_cmd[47:16] <= RvviAxiRdata;
        W_ARG:   r_arg        <= RvviAxiRdata;
        default: ;
      endcase

      if (RvviAxiRlast) begin
        r_state <= ST_IDLE;
        r_widx  <= '0;
        r_drop  <= 1'b0;
      end else begin
        if (r_widx != W_SAT) r_widx <= r_widx + 3'd1;
        r_drop <= w_drop_now;
        case (r_state)
          ST_IDLE:  r_state <= w_drop_now ? ST_DRAIN : ST_HDR;
          ST_HDR: begin
            if (w_drop_now)               r_state <= ST_DRAIN;
            else if (r_widx == W_ETYPE)   r_state <= ST_CMD;
          end
          ST_CMD: begin
            if (w_drop_now || (r_widx == W_ARG)) r_state <= ST_DRAIN;
          end
          default:  r_state <= ST_DRAIN;
        endcase
      end
    end
  end

  // Pulses are registered from the Rlast beat, so a following frame cannot cancel them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trigger_pulse <= 1'b0;
      r_slow_pulse    <= 1'b0;
      r_host_fill     <= '0;
    end else begin
      r_trigger_pulse <= w_accept && (w_cmd_kind == CMD_TRIGGER);
      r_slow_pulse    <= w_accept && (w_cmd_kind == CMD_SLOW);
      if (w_accept && (w_cmd_kind == CMD_SLOW)) r_host_fill <= w_arg;
    end
  end

  assign RvviAxiRready = w_ready;
  assign TriggerPulse  = r_trigger_pulse;
  assign SlowPulse     = r_slow_pulse;
  assign HostFillAmt   = r_host_fill;

`ifdef RVVI_RX_STATS_EN
  logic w_frame_inc;
  logic w_drop_inc;

  assign w_frame_inc = w_accept;
  assign w_drop_inc  = w_last & ~w_accept;

  rvvi_sat_counter u_frame_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_frame_inc),
    .o_count (FrameCount)
  );

  rvvi_sat_counter u_drop_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_drop_inc),
    .o_count (DropCount)
  );
`else
  assign FrameCount = '0;
  assign DropCount  = '0;
`endif

endmodule
